// File: rtl/memory_map.sv
// memory_map: data-memory subsystem behind the Hack CPU.
//   Regions: data RAM [0x0000,0x3FFF], screen shadow [0x4000,0x5FFF],
//   keyboard register at 0x6000. Everything above 0x6000 reads as 0.
//   Screen writes update the shadow RAM and are queued toward the display
//   controller. fb_valid/fb_ready is the handshake; a pop happens when both are high.
// Ports:
//   clk, reset (async, active low)
//   addressM/outM/writeM  CPU memory bus in; inM registered read data out (latency 1)
//   fb_addr/fb_data/fb_valid/fb_ready  screen-write queue head toward the display
//   kbd_code/kbd_strobe   keyboard front end; the strobe latches the code
//   overflow              sticky: a screen write found the queue full and was dropped
module memory_map #(
    parameter int RAM_WORDS  = 16384,
    parameter int SCR_WORDS  = 8192,
    parameter int KBD_ADDR   = 24576,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    output logic [12:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        fb_valid,
    input  logic        fb_ready,
    input  logic [15:0] kbd_code,
    input  logic        kbd_strobe,
    output logic        overflow
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCR_WORDS);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    logic [15:0] ram [RAM_WORDS];
    logic [15:0] scr [SCR_WORDS];
    logic [12:0] f_addr [FIFO_DEPTH];
    logic [15:0] f_data [FIFO_DEPTH];

    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [15:0]       kbd_reg;
    logic [15:0]       addr_ext;
    logic              ram_sel, scr_sel, kbd_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_off;
    logic [15:0]       rd_data;
    logic              push_req, push, pop, full;

    // Region decode
    assign addr_ext = {1'b0, addressM};
    assign ram_sel  = addr_ext < 16'(RAM_WORDS);
    assign scr_sel  = !ram_sel && (addr_ext < 16'(RAM_WORDS + SCR_WORDS));
    assign kbd_sel  = addr_ext == 16'(KBD_ADDR);
    assign ram_idx  = addressM[RAM_AW-1:0];
    // The screen base sits on a multiple of the screen size, so the low
    // address bits are already the offset from the base.
    assign scr_off  = addressM[SCR_AW-1:0];

    always_comb begin
        rd_data = '0;
        if (ram_sel)      rd_data = ram[ram_idx];
        else if (scr_sel) rd_data = scr[scr_off];
        else if (kbd_sel) rd_data = kbd_reg;
    end

    // Storage arrays are not reset.
    always_ff @(posedge clk) begin
        if (writeM && ram_sel) ram[ram_idx] <= outM;
        if (writeM && scr_sel) scr[scr_off] <= outM;
        if (push) begin
            f_addr[wr_ptr] <= 13'(scr_off);
            f_data[wr_ptr] <= outM;
        end
    end

    // Registered read; a write in the same edge is forwarded (write-first).
    // The keyboard is read before this edge's strobe takes effect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inM     <= '0;
            kbd_reg <= '0;
        end else begin
            inM <= (writeM && (ram_sel || scr_sel)) ? outM : rd_data;
            if (kbd_strobe) kbd_reg <= kbd_code;
        end
    end

    // Screen-write queue. A pop in the same edge frees a slot for a push
    // even when full.
    assign full     = count == CW'(FIFO_DEPTH);
    assign fb_valid = count != '0;
    assign pop      = fb_valid && fb_ready;
    assign push_req = writeM && scr_sel;
    assign push     = push_req && (!full || pop);
    assign fb_addr  = f_addr[rd_ptr];
    assign fb_data  = f_data[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push_req && !push) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_map.sv
// Testbench for memory_map: a reference model built from associative
// memory, a queue for the screen FIFO and a keyboard variable, compared
// against the DUT on every falling edge, plus literal expectations for the
// directed scenarios.
module tb_memory_map;
    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [12:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_valid;
    logic        fb_ready;
    logic [15:0] kbd_code;
    logic        kbd_strobe;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    memory_map dut (
        .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
        .inM(inM), .fb_addr(fb_addr), .fb_data(fb_data), .fb_valid(fb_valid),
        .fb_ready(fb_ready), .kbd_code(kbd_code), .kbd_strobe(kbd_strobe),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model
    typedef struct {
        logic [12:0] a;
        logic [15:0] d;
    } ent_t;

    logic [15:0] m_mem [int];
    ent_t        m_q [$];
    logic [15:0] m_inm   = '0;
    bit          m_known = 1'b0;
    logic [15:0] m_kbd   = '0;
    bit          m_ovf   = 1'b0;

    always @(posedge clk or negedge reset) begin
        int a;
        int sz;
        bit popped;
        if (!reset) begin
            m_inm   = '0;
            m_known = 1'b1;
            m_q.delete();
            m_kbd   = '0;
            m_ovf   = 1'b0;
        end else begin
            a = int'(addressM);
            if (a < 'h6000) begin
                if (writeM) begin
                    m_inm = outM; m_known = 1'b1;
                end else if (m_mem.exists(a)) begin
                    m_inm = m_mem[a]; m_known = 1'b1;
                end else begin
                    m_known = 1'b0;
                end
            end else if (a == 'h6000) begin
                m_inm = m_kbd; m_known = 1'b1;
            end else begin
                m_inm = '0; m_known = 1'b1;
            end
            if (writeM && a < 'h6000) m_mem[a] = outM;
            sz     = m_q.size();
            popped = (sz != 0) && fb_ready;
            if (popped) void'(m_q.pop_front());
            if (writeM && a >= 'h4000 && a < 'h6000) begin
                if (sz < 8 || popped) m_q.push_back('{a: 13'(a - 'h4000), d: outM});
                else m_ovf = 1'b1;
            end
            if (kbd_strobe) m_kbd = kbd_code;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) chk("model_inM", inM, m_inm);
        chk("model_fb_valid", 16'(fb_valid), 16'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("model_fb_addr", 16'(fb_addr), 16'(m_q[0].a));
            chk("model_fb_data", fb_data, m_q[0].d);
        end
        chk("model_overflow", 16'(overflow), 16'(m_ovf));
    end

    // One bus cycle: drive, let the edge sample, return 1 time unit later.
    task automatic cyc(input logic [14:0] a, input logic [15:0] d, input logic w);
        addressM = a; outM = d; writeM = w;
        @(posedge clk);
        #1;
        writeM = 1'b0;
    endtask

    initial begin
        reset = 1'b0; addressM = '0; outM = '0; writeM = 1'b0;
        fb_ready = 1'b0; kbd_code = '0; kbd_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inM", inM, 16'h0);
        chk("reset_fb_valid", 16'(fb_valid), 16'h0);
        chk("reset_overflow", 16'(overflow), 16'h0);
        reset = 1'b1;
        cyc(15'h0000, 16'h0, 1'b0);

        // RAM write-first, read back, unmapped read and write
        cyc(15'h0010, 16'h1234, 1'b1);
        chk("ram_write_first", inM, 16'h1234);
        cyc(15'h0000, 16'h0, 1'b0);
        cyc(15'h0010, 16'h0, 1'b0);
        chk("ram_read", inM, 16'h1234);
        cyc(15'h7000, 16'hFFFF, 1'b1);
        cyc(15'h7000, 16'h0, 1'b0);
        chk("unmapped_read", inM, 16'h0);
        cyc(15'h3FFF, 16'h0A0A, 1'b1);
        cyc(15'h3FFF, 16'h0, 1'b0);
        chk("ram_top_read", inM, 16'h0A0A);

        // Screen write with display ready
        fb_ready = 1'b1;
        cyc(15'h4005, 16'hBEEF, 1'b1);
        chk("scr_fb_valid", 16'(fb_valid), 16'h1);
        chk("scr_fb_addr", 16'(fb_addr), 16'h0005);
        chk("scr_fb_data", fb_data, 16'hBEEF);
        cyc(15'h4005, 16'h0, 1'b0);
        chk("scr_popped", 16'(fb_valid), 16'h0);
        chk("scr_shadow_read", inM, 16'hBEEF);

        // Overflow: nine writes with display stalled
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) cyc(15'(16'h4100 + i), 16'(16'hA000 + i), 1'b1);
        chk("ovf_set", 16'(overflow), 16'h1);
        chk("ovf_head", 16'(fb_addr), 16'h0100);
        cyc(15'h5FFF, 16'h7777, 1'b1);
        cyc(15'h0000, 16'h0, 1'b0);
        fb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_addr", 16'(fb_addr), 16'(16'h0100 + i));
            chk("drain_data", fb_data, 16'(16'hA000 + i));
            cyc(15'h0000, 16'h0, 1'b0);
        end
        chk("drain_empty", 16'(fb_valid), 16'h0);
        chk("ovf_sticky", 16'(overflow), 16'h1);
        cyc(15'h5FFF, 16'h0, 1'b0);
        chk("dropped_still_shadowed", inM, 16'h7777);

        // Keyboard
        kbd_code = 16'h0041; kbd_strobe = 1'b1;
        cyc(15'h6000, 16'h0, 1'b0);
        kbd_strobe = 1'b0;
        chk("kbd_same_cycle_old", inM, 16'h0000);
        cyc(15'h6000, 16'h0, 1'b0);
        chk("kbd_read", inM, 16'h0041);
        cyc(15'h6000, 16'h5555, 1'b1);
        chk("kbd_write_ignored", inM, 16'h0041);
        kbd_code = 16'h0000; kbd_strobe = 1'b1;
        cyc(15'h0000, 16'h0, 1'b0);
        kbd_strobe = 1'b0;
        cyc(15'h6000, 16'h0, 1'b0);
        chk("kbd_release", inM, 16'h0000);

        // Asynchronous reset with three entries queued
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(15'(16'h4010 + i), 16'(16'hD000 + i), 1'b1);
        chk("pre_reset_valid", 16'(fb_valid), 16'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_fb_valid", 16'(fb_valid), 16'h0);
        chk("async_inM", inM, 16'h0);
        chk("async_overflow", 16'(overflow), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(15'h0010, 16'h0, 1'b0);
        chk("ram_persists", inM, 16'h1234);
        cyc(15'h4011, 16'h0, 1'b0);
        chk("shadow_persists", inM, 16'hD001);

        // Full FIFO: push and pop in the same edge
        for (int i = 0; i < 8; i++) cyc(15'(16'h4200 + i), 16'(16'hC000 + i), 1'b1);
        chk("full_no_ovf", 16'(overflow), 16'h0);
        fb_ready = 1'b1;
        cyc(15'h4208, 16'hC008, 1'b1);
        chk("full_pushpop_ovf", 16'(overflow), 16'h0);
        for (int i = 0; i < 8; i++) begin
            chk("full_drain_addr", 16'(fb_addr), 16'(16'h0201 + i));
            chk("full_drain_data", fb_data, 16'(16'hC001 + i));
            cyc(15'h0000, 16'h0, 1'b0);
        end
        chk("full_drain_empty", 16'(fb_valid), 16'h0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
